// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexed driver for a multi-digit seven-segment display. A hex value
// with per-digit decimal points is accepted through a valid/ready handshake,
// parked in a pending buffer, and copied into the display registers only at a
// frame boundary so a frame is never shown half old / half new. The display
// registers are scanned one digit at a time; every output is registered.
//
// Parameters
//   clk_mhz     system clock frequency in MHz
//   w_digit     number of digits (1..16)
//   digit_hz    digit switch rate; each digit is lit for
//               period = clk_mhz * 1_000_000 / digit_hz cycles (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   number       hex value, nibble i drives digit i (digit 0 = LSB)
//   dots         decimal point per digit
//   blank_zeros  enable leading-zero blanking
//   valid        producer offers number/dots/blank_zeros
//   ready        offer can be accepted (equals !pending, registered state only)
//   frame_start  one-cycle pulse with the first cycle digit 0 is shown
//   abcdefgh     segments, active high: [7]=a .. [1]=g, [0]=h (dot)
//   digit        one-hot digit select, active high
//
// Handshake: a transfer happens on a rising edge where valid && ready. ready
// is a pure function of registered state; valid may be dropped at any time
// and an offer made while ready is low is simply ignored (not held).
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
   parameter int clk_mhz  = 50,
   parameter int w_digit  = 8,
   parameter int digit_hz = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [w_digit*4-1:0] number,
   input  logic [w_digit-1:0]   dots,
   input  logic                 blank_zeros,
   input  logic                 valid,
   output logic                 ready,
   output logic                 frame_start,
   output logic [7:0]           abcdefgh,
   output logic [w_digit-1:0]   digit
);

   localparam int period = clk_mhz * 1_000_000 / digit_hz;
   localparam int cw     = (period > 1) ? $clog2(period) : 1;
   localparam int iw     = (w_digit > 1) ? $clog2(w_digit) : 1;

   // ---------------------------------------------------------------------------
   // Scan position
   // ---------------------------------------------------------------------------
   logic [cw-1:0] cnt;
   logic [iw-1:0] idx;
   logic          last_cnt;
   logic          last_idx;
   logic          boundary;

   assign last_cnt = (cnt == cw'(period - 1));
   assign last_idx = (idx == iw'(w_digit - 1));
   // Last cycle of the last digit: the only point where the display may change.
   assign boundary = last_cnt && last_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (last_cnt) begin
         cnt <= '0;
         idx <= last_idx ? '0 : idx + iw'(1);
      end else begin
         cnt <= cnt + cw'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Pending buffer and display registers
   // ---------------------------------------------------------------------------
   logic [w_digit*4-1:0] pend_num;
   logic [w_digit-1:0]   pend_dots;
   logic                 pend_blank;
   logic                 pending;

   logic [w_digit*4-1:0] disp_num;
   logic [w_digit-1:0]   disp_dots;
   logic                 disp_blank;

   assign ready = !pending;

   // Accept and transfer are mutually exclusive: accepting needs pending == 0,
   // transferring needs pending == 1, so the if/else never drops either one.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_num   <= '0;
         pend_dots  <= '0;
         pend_blank <= 1'b0;
         pending    <= 1'b0;
         disp_num   <= '0;
         disp_dots  <= '0;
         disp_blank <= 1'b0;
      end else if (pending && boundary) begin
         disp_num   <= pend_num;
         disp_dots  <= pend_dots;
         disp_blank <= pend_blank;
         pending    <= 1'b0;
      end else if (valid && !pending) begin
         pend_num   <= number;
         pend_dots  <= dots;
         pend_blank <= blank_zeros;
         pending    <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit decode
   // ---------------------------------------------------------------------------
   logic [3:0]         nib [w_digit];
   // upper_zero[i] is set when nibbles i .. w_digit-1 are all zero.
   logic [w_digit:0]   upper_zero;
   logic [3:0]         cur_nib;
   logic [6:0]         seg7;
   logic               cur_blank;
   logic [7:0]         next_seg;
   logic [w_digit-1:0] next_digit;

   always_comb begin
      upper_zero          = '0;
      upper_zero[w_digit] = 1'b1;
      for (int i = 0; i < w_digit; i++) begin
         nib[i] = disp_num[i*4 +: 4];
      end
      for (int i = w_digit - 1; i >= 0; i--) begin
         upper_zero[i] = upper_zero[i+1] && (nib[i] == 4'h0);
      end
   end

   assign cur_nib = nib[idx];

   always_comb begin
      seg7 = 7'b0000000;
      case (cur_nib)
         4'h0: seg7 = 7'b1111110;
         4'h1: seg7 = 7'b0110000;
         4'h2: seg7 = 7'b1101101;
         4'h3: seg7 = 7'b1111001;
         4'h4: seg7 = 7'b0110011;
         4'h5: seg7 = 7'b1011011;
         4'h6: seg7 = 7'b1011111;
         4'h7: seg7 = 7'b1110000;
         4'h8: seg7 = 7'b1111111;
         4'h9: seg7 = 7'b1111011;
         4'hA: seg7 = 7'b1110111;
         4'hB: seg7 = 7'b0011111;
         4'hC: seg7 = 7'b1001110;
         4'hD: seg7 = 7'b0111101;
         4'hE: seg7 = 7'b1001111;
         4'hF: seg7 = 7'b1000111;
         default: seg7 = 7'b0000000;
      endcase
   end

   // Digit 0 always shows something, so a zero value still reads "0".
   // The dot is outside the blanking so a lone decimal point stays visible.
   assign cur_blank = disp_blank && (idx != '0) && upper_zero[idx];
   assign next_seg  = {(cur_blank ? 7'b0000000 : seg7), disp_dots[idx]};

   always_comb begin
      next_digit = '0;
      for (int i = 0; i < w_digit; i++) begin
         next_digit[i] = (idx == iw'(i));
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs: one cycle behind the scan position.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         digit       <= '0;
         abcdefgh    <= '0;
         frame_start <= 1'b0;
      end else begin
         digit       <= next_digit;
         abcdefgh    <= next_seg;
         frame_start <= (cnt == '0) && (idx == '0);
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Bench for seven_segment_scanner with period = 4 and 8 digits. A reference
// model tracks time since reset as a plain cycle count, derives the shown
// digit from it arithmetically, and keeps the accepted/pending/displayed
// values; a negedge monitor compares every cycle against it. Scenario tasks
// add fixed-value checks from hand-decoded segment patterns.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

   localparam int W      = 8;
   localparam int PERIOD = 4;
   localparam int FRAME  = W * PERIOD;

   logic          clk = 1'b0;
   logic          rst;
   logic [W*4-1:0] number;
   logic [W-1:0]  dots;
   logic          blank_zeros;
   logic          valid;
   logic          ready;
   logic          frame_start;
   logic [7:0]    abcdefgh;
   logic [W-1:0]  digit;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   seven_segment_scanner #(
      .clk_mhz (1),
      .w_digit (W),
      .digit_hz(250000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .number     (number),
      .dots       (dots),
      .blank_zeros(blank_zeros),
      .valid      (valid),
      .ready      (ready),
      .frame_start(frame_start),
      .abcdefgh   (abcdefgh),
      .digit      (digit)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [6:0] seg_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   logic [7:0] full_tab  [8] = '{8'h7B, 8'h9C, 8'h3E, 8'hEE, 8'hF2, 8'hDA, 8'h60, 8'hFC};
   logic [7:0] blank_tab [8] = '{8'hFC, 8'hB6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

   function automatic logic [7:0] seg_of(logic [31:0] num, logic [7:0] dts,
                                         logic blank, int pos);
      logic [31:0] upper;
      logic [6:0]  s;
      upper = num >> (4 * pos);
      s     = seg_tab[upper[3:0]];
      if (pos > 0 && blank && upper == 32'h0) s = 7'b0;
      return {s, dts[pos]};
   endfunction

   int         mt;
   int         m_phase;
   int         m_pos;
   bit         m_pending;
   logic [31:0] m_pnum, m_dnum;
   logic [7:0]  m_pdots, m_ddots;
   logic        m_pblank, m_dblank;
   logic [7:0]  exp_digit, exp_seg;
   logic        exp_fs, exp_ready;

   always @(posedge clk) begin
      if (rst) begin
         mt = 0; m_pending = 0;
         m_pnum = 0; m_pdots = 0; m_pblank = 0;
         m_dnum = 0; m_ddots = 0; m_dblank = 0;
         exp_digit = 0; exp_seg = 0; exp_fs = 0;
      end else begin
         m_phase   = mt % FRAME;
         m_pos     = m_phase / PERIOD;
         exp_digit = 8'(1 << m_pos);
         exp_seg   = seg_of(m_dnum, m_ddots, m_dblank, m_pos);
         exp_fs    = (m_phase == 0);
         if (m_phase == FRAME - 1 && m_pending) begin
            m_dnum = m_pnum; m_ddots = m_pdots; m_dblank = m_pblank;
            m_pending = 0;
         end else if (valid && !m_pending) begin
            m_pnum = number; m_pdots = dots; m_pblank = blank_zeros;
            m_pending = 1;
         end
         mt++;
      end
      exp_ready = !m_pending;
   end

   always @(negedge clk) begin
      if (check_en) begin
         n_checks++;
         if ({ready, frame_start, digit, abcdefgh} !== {exp_ready, exp_fs, exp_digit, exp_seg}) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got ready=%b fs=%b digit=%h seg=%h, expected ready=%b fs=%b digit=%h seg=%h",
                     $time, ready, frame_start, digit, abcdefgh, exp_ready, exp_fs, exp_digit, exp_seg);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic offer(input logic [31:0] num, input logic [7:0] d, input logic b);
      @(negedge clk);
      valid = 1'b1; number = num; dots = d; blank_zeros = b;
      @(negedge clk);
      valid = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; number = '0; dots = '0; blank_zeros = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ready, frame_start, digit, abcdefgh} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_values got ready=%b fs=%b digit=%h seg=%h, expected 1 0 00 00",
                  ready, frame_start, digit, abcdefgh);
      end
      check_en = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {1'b1, 8'h01, 8'hFC}) begin
         n_fail++;
         $display("FAIL first_cycle got fs=%b digit=%h seg=%h, expected 1 01 fc",
                  frame_start, digit, abcdefgh);
      end
   endtask

   task automatic test_scan();
      int fs_count;
      logic [7:0] want;
      fs_count = 1;
      for (int k = 1; k < 2 * FRAME; k++) begin
         @(negedge clk);
         want = 8'(1 << ((k / PERIOD) % W));
         n_checks++;
         if (digit !== want || abcdefgh !== 8'hFC) begin
            n_fail++;
            $display("FAIL scan_step k=%0d got digit=%h seg=%h, expected digit=%h seg=fc",
                     k, digit, abcdefgh, want);
         end
         if (frame_start === 1'b1) fs_count++;
      end
      n_checks++;
      if (fs_count != 2) begin
         n_fail++;
         $display("FAIL scan_frame_pulses got %0d, expected 2", fs_count);
      end
   endtask

   task automatic test_full_update();
      bit ok;
      wait_frame(ok);
      repeat (10) @(negedge clk);
      offer(32'h0123ABCD, 8'h01, 1'b0);
      n_checks++;
      if (ready !== 1'b0 || abcdefgh !== 8'hFC) begin
         n_fail++;
         $display("FAIL full_accept got ready=%b seg=%h, expected ready=0 seg=fc", ready, abcdefgh);
      end
      wait_frame(ok);
      n_checks++;
      if (!ok || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_frame got found=%0d ready=%b, expected found=1 ready=1", ok, ready);
      end
      for (int d = 0; d < W; d++) begin
         n_checks++;
         if (digit !== 8'(1 << d) || abcdefgh !== full_tab[d]) begin
            n_fail++;
            $display("FAIL full_digit%0d got digit=%h seg=%h, expected seg=%h",
                     d, digit, abcdefgh, full_tab[d]);
         end
         if (d < W - 1) repeat (PERIOD) @(negedge clk);
      end
   endtask

   task automatic test_blanking();
      bit ok;
      offer(32'h00000050, 8'h80, 1'b1);
      wait_frame(ok);
      for (int d = 0; d < W; d++) begin
         n_checks++;
         if (!ok || abcdefgh !== blank_tab[d]) begin
            n_fail++;
            $display("FAIL blank_digit%0d got seg=%h found=%0d, expected seg=%h",
                     d, abcdefgh, ok, blank_tab[d]);
         end
         if (d < W - 1) repeat (PERIOD) @(negedge clk);
      end
      offer(32'h0, 8'h00, 1'b1);
      wait_frame(ok);
      for (int d = 0; d < W; d++) begin
         n_checks++;
         if (!ok || abcdefgh !== ((d == 0) ? 8'hFC : 8'h00)) begin
            n_fail++;
            $display("FAIL zero_digit%0d got seg=%h found=%0d", d, abcdefgh, ok);
         end
         if (d < W - 1) repeat (PERIOD) @(negedge clk);
      end
   endtask

   logic [31:0] val_b;
   logic [7:0]  dots_b;

   task automatic test_back_to_back();
      bit ok;
      logic [31:0] a;
      logic [7:0]  da;
      a = $urandom; da = 8'($urandom);
      val_b = $urandom; dots_b = 8'($urandom);
      val_b[3:0] = a[3:0] + 4'h1;
      wait_frame(ok);
      repeat (6) @(negedge clk);
      valid = 1'b1; number = a; dots = da; blank_zeros = 1'b0;
      @(negedge clk);
      number = val_b; dots = dots_b;
      @(negedge clk);
      valid = 1'b0;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ready got %b, expected 0", ready);
      end
      wait_frame(ok);
      n_checks++;
      if (!ok || abcdefgh !== {seg_tab[a[3:0]], da[0]}) begin
         n_fail++;
         $display("FAIL b2b_first got seg=%h, expected %h", abcdefgh, {seg_tab[a[3:0]], da[0]});
      end
      valid = 1'b1; number = val_b; dots = dots_b; blank_zeros = 1'b0;
      @(negedge clk);
      valid = 1'b0;
      wait_frame(ok);
      n_checks++;
      if (!ok || abcdefgh !== {seg_tab[val_b[3:0]], dots_b[0]}) begin
         n_fail++;
         $display("FAIL b2b_reoffer got seg=%h, expected %h", abcdefgh, {seg_tab[val_b[3:0]], dots_b[0]});
      end
   endtask

   task automatic test_boundary_offer();
      bit ok;
      logic [31:0] c;
      c = $urandom;
      c[3:0] = val_b[3:0] + 4'h3;
      wait_frame(ok);
      // Frame pulse is seen two edges after the boundary edge; 30 more
      // negedges put the offer on the next boundary edge.
      repeat (FRAME - 2) @(negedge clk);
      valid = 1'b1; number = c; dots = 8'h00; blank_zeros = 1'b0;
      @(negedge clk);
      valid = 1'b0;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL edge_accept got ready=%b, expected 0", ready);
      end
      wait_frame(ok);
      n_checks++;
      if (!ok || ready !== 1'b0 || abcdefgh !== {seg_tab[val_b[3:0]], dots_b[0]}) begin
         n_fail++;
         $display("FAIL edge_not_yet got ready=%b seg=%h, expected ready=0 seg=%h",
                  ready, abcdefgh, {seg_tab[val_b[3:0]], dots_b[0]});
      end
      wait_frame(ok);
      n_checks++;
      if (!ok || ready !== 1'b1 || abcdefgh !== {seg_tab[c[3:0]], 1'b0}) begin
         n_fail++;
         $display("FAIL edge_shown got ready=%b seg=%h, expected ready=1 seg=%h",
                  ready, abcdefgh, {seg_tab[c[3:0]], 1'b0});
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      logic [31:0] v;
      v = $urandom;
      v[3:0] = 4'($urandom_range(1, 15));
      wait_frame(ok);
      valid = 1'b1; number = v; dots = 8'hFF; blank_zeros = 1'b0;
      @(negedge clk);
      valid = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({ready, frame_start, digit, abcdefgh} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
         n_fail++;
         $display("FAIL midrst_values got ready=%b fs=%b digit=%h seg=%h, expected 1 0 00 00",
                  ready, frame_start, digit, abcdefgh);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({frame_start, digit, abcdefgh} !== {1'b1, 8'h01, 8'hFC}) begin
         n_fail++;
         $display("FAIL midrst_restart got fs=%b digit=%h seg=%h, expected 1 01 fc",
                  frame_start, digit, abcdefgh);
      end
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         n_checks++;
         if (abcdefgh !== 8'hFC || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_lost k=%0d got seg=%h ready=%b, expected fc 1", k, abcdefgh, ready);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         valid       = ($urandom_range(0, 5) == 0);
         number      = $urandom >> $urandom_range(0, 31);
         dots        = 8'($urandom);
         blank_zeros = 1'($urandom_range(0, 1));
         rst         = ($urandom_range(0, 250) == 0);
      end
      @(negedge clk);
      valid = 1'b0; rst = 1'b0;
      repeat (FRAME) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_scan();
      test_full_update();
      test_blanking();
      test_back_to_back();
      test_boundary_offer();
      test_mid_reset();
      test_random();
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
